// File: rtl/cheat_pgm_loader.sv
// rtl/cheat_pgm_loader.sv - MCU byte stream to cheat-engine word writes, with hold-aware FIFO.
// Optional per-frame XOR checksum byte enabled by CHEAT_PGM_CSUM_EN.
module cheat_pgm_loader #(
  parameter int         DEPTH     = 4,
  parameter logic [4:0] HDR_MATCH = 5'b10011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_start,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_data,
  input  logic                     pgm_hold,
  input  logic                     clr_status,
  output logic                     pgm_we,
  output logic [2:0]               pgm_idx,
  output logic [31:0]              pgm_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     csum_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, SKIP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          push_req;
  logic          take_hdr;
  logic          hdr_ok;

  logic [34:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full, pop, push_ok, drop;
  logic          pgm_we_q;
  logic [2:0]    pgm_idx_q;
  logic [31:0]   pgm_in_q;
  logic          overflow_q;

`ifdef CHEAT_PGM_CSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          csum_bad;
  logic          csum_err_q;
`endif

  assign hdr_ok   = (cmd_data[7:3] == HDR_MATCH);
  // A start byte is always a header; in IDLE an unmarked byte is too.
  assign take_hdr = cmd_valid && (cmd_start || state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    push_req = 1'b0;
`ifdef CHEAT_PGM_CSUM_EN
    csum_d   = csum_q;
    csum_bad = 1'b0;
`endif
    if (take_hdr) begin
      if (hdr_ok) begin
        state_d = PAYLOAD;
        idx_d   = cmd_data[2:0];
        bcnt_d  = 2'd0;
`ifdef CHEAT_PGM_CSUM_EN
        csum_d  = cmd_data;
`endif
      end else begin
        state_d = SKIP;
      end
    end else if (cmd_start) begin
      state_d = IDLE;
    end else if (cmd_valid) begin
      case (state_q)
        PAYLOAD: begin
          word_d = {word_q[23:0], cmd_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef CHEAT_PGM_CSUM_EN
          csum_d = csum_q ^ cmd_data;
          if (bcnt_q == 2'd3) state_d = CSUM;
`else
          if (bcnt_q == 2'd3) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end
`endif
        end
`ifdef CHEAT_PGM_CSUM_EN
        CSUM: begin
          if (cmd_data == csum_q) push_req = 1'b1;
          else                    csum_bad = 1'b1;
          state_d = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign pop     = (level_q != '0) && !pgm_hold;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && !push_ok;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= {idx_q, word_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      pgm_we_q   <= 1'b0;
      pgm_idx_q  <= '0;
      pgm_in_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      level_q    <= level_d;
      pgm_we_q   <= pop;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q    <= rptr_q + 1'b1;
        pgm_idx_q <= mem_q[rptr_q][34:32];
        pgm_in_q  <= mem_q[rptr_q][31:0];
      end
      // A set event in the same cycle as a clear wins.
      overflow_q <= (overflow_q && !clr_status) || drop;
    end
  end

`ifdef CHEAT_PGM_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= (csum_err_q && !clr_status) || csum_bad;
    end
  end
  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif

  assign pgm_we   = pgm_we_q;
  assign pgm_idx  = pgm_idx_q;
  assign pgm_in   = pgm_in_q;
  assign overflow = overflow_q;
  assign level    = level_q;
  assign busy     = (state_q == PAYLOAD) || (state_q == CSUM) || (level_q != '0);
endmodule

// File: tb/tb_cheat_pgm_loader.sv
// tb/tb_cheat_pgm_loader.sv - randomized self-checking bench for cheat_pgm_loader.
// Frames are scored against an ordered list of expected {idx, word} writes.
module tb_cheat_pgm_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_valid = 1'b0, pgm_hold = 1'b0, clr_status = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        pgm_we, overflow, csum_err, busy;
  logic [2:0]  pgm_idx;
  logic [31:0] pgm_in;
  logic [2:0]  level;

  int checks = 0, passed = 0, cyc = 0;
  logic [34:0] obs_q[$];
  int          obs_cyc[$];
  logic [34:0] exp_q[$];
  logic [7:0]  fb[$];

  cheat_pgm_loader #(.DEPTH(4), .HDR_MATCH(5'b10011)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .pgm_hold(pgm_hold), .clr_status(clr_status),
    .pgm_we(pgm_we), .pgm_idx(pgm_idx), .pgm_in(pgm_in), .busy(busy),
    .level(level), .overflow(overflow), .csum_err(csum_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && pgm_we) begin
    obs_q.push_back({pgm_idx, pgm_in});
    obs_cyc.push_back(cyc);
  end

  task automatic build(input logic [7:0] hdr, input logic [31:0] w);
    logic [7:0] x;
    fb.delete();
    fb.push_back(hdr);
    x = hdr;
    for (int i = 3; i >= 0; i--) begin
      fb.push_back(w[8*i +: 8]);
      x = x ^ w[8*i +: 8];
    end
`ifdef CHEAT_PGM_CSUM_EN
    fb.push_back(x);
`endif
  endtask

  task automatic send_byte(input logic st, input logic [7:0] b);
    cmd_start = st; cmd_valid = 1'b1; cmd_data = b;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] w);
    build(hdr, w);
    foreach (fb[i]) send_byte(i == 0, fb[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (pgm_we !== 1'b0)    $display("FAIL reset_we got %b exp 0", pgm_we);   else passed++;
    checks++; if (pgm_idx !== 3'd0)   $display("FAIL reset_idx got %0d exp 0", pgm_idx); else passed++;
    checks++; if (pgm_in !== 32'd0)   $display("FAIL reset_in got %h exp 0", pgm_in);   else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL reset_busy got %b exp 0", busy);   else passed++;
    checks++; if (level !== 3'd0)     $display("FAIL reset_level got %0d exp 0", level); else passed++;
    checks++; if (overflow !== 1'b0)  $display("FAIL reset_ovf got %b exp 0", overflow); else passed++;
    checks++; if (csum_err !== 1'b0)  $display("FAIL reset_csum got %b exp 0", csum_err); else passed++;
  endtask

  task automatic test_single;
    send_frame(8'h9A, 32'h7E0010FF);
    checks++; if (pgm_we !== 1'b0) $display("FAIL single_early got we=%b exp 0", pgm_we); else passed++;
    idle(1);
    checks++; if (pgm_we !== 1'b1) $display("FAIL single_we got %b exp 1", pgm_we); else passed++;
    checks++; if (pgm_idx !== 3'd2) $display("FAIL single_idx got %0d exp 2", pgm_idx); else passed++;
    checks++; if (pgm_in !== 32'h7E0010FF) $display("FAIL single_in got %h exp 7e0010ff", pgm_in); else passed++;
    idle(1);
    checks++; if (pgm_we !== 1'b0) $display("FAIL single_pulse got we=%b exp 0", pgm_we); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy got %b exp 0", busy); else passed++;
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_overflow;
    logic [31:0] w;
    exp_q.delete();
    pgm_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      exp_q.push_back({3'(i), w});
      send_frame(8'h98 | 8'(i), w);
    end
    idle(2);
    checks++; if (level !== 3'd4) $display("FAIL ovf_level got %0d exp 4", level); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL ovf_held got %0d writes exp 0", obs_q.size()); else passed++;
    send_frame(8'h9D, $urandom);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else passed++;
    checks++; if (level !== 3'd4) $display("FAIL ovf_level2 got %0d exp 4", level); else passed++;
    pgm_hold = 1'b0;
    idle(8);
    checks++; if (obs_q.size() != 4) $display("FAIL ovf_count got %0d exp 4", obs_q.size()); else passed++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_order[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else passed++;
      checks++; if (obs_cyc[i] != obs_cyc[0] + i) $display("FAIL ovf_consec[%0d] got cyc %0d exp %0d", i, obs_cyc[i], obs_cyc[0] + i); else passed++;
    end
    clr_status = 1'b1; idle(1); clr_status = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else passed++;
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_abort;
    send_byte(1'b1, 8'h9E); send_byte(1'b0, 8'h12); send_byte(1'b0, 8'h34);
    send_frame(8'h99, 32'hAABBCCDD);
    idle(4);
    checks++; if (obs_q.size() != 1) $display("FAIL abort_count got %0d exp 1", obs_q.size()); else passed++;
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== {3'd1, 32'hAABBCCDD}) $display("FAIL abort_data got %h exp %h", obs_q[0], {3'd1, 32'hAABBCCDD}); else passed++;
    end
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_skip;
    send_byte(1'b1, 8'h55);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'h98 + 8'(i));
    idle(4);
    checks++; if (obs_q.size() != 0) $display("FAIL skip_none got %0d writes exp 0", obs_q.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL skip_busy got %b exp 0", busy); else passed++;
    send_frame(8'h98, 32'h01234567);
    idle(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {3'd0, 32'h01234567})
      $display("FAIL skip_after got n=%0d %h exp 1 write %h", obs_q.size(), obs_q.size() ? obs_q[0] : 35'd0, {3'd0, 32'h01234567}); else passed++;
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_push_pop_full;
    logic [31:0] w;
    exp_q.delete();
    pgm_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      exp_q.push_back({3'(7 - i), w});
      send_frame(8'h98 | 8'(7 - i), w);
    end
    w = $urandom;
    exp_q.push_back({3'd3, w});
    build(8'h9B, w);
    foreach (fb[i]) begin
      if (i == fb.size() - 1) pgm_hold = 1'b0;
      send_byte(i == 0, fb[i]);
    end
    checks++; if (level !== 3'd4) $display("FAIL pp_level got %0d exp 4", level); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL pp_ovf got %b exp 0", overflow); else passed++;
    idle(8);
    checks++; if (obs_q.size() != 5) $display("FAIL pp_count got %0d exp 5", obs_q.size()); else passed++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL pp_order[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_random;
    int kind;
    logic [7:0] h;
    logic [31:0] w;
    exp_q.delete();
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 5);
      w = $urandom;
      if (kind <= 3) begin
        h = 8'h98 | 8'($urandom_range(0, 7));
        exp_q.push_back({h[2:0], w});
        build(h, w);
      end else if (kind == 4) begin
        h = 8'($urandom);
        if (h[7:3] == 5'b10011) h[7] = 1'b0;
        build(h, w);
      end else begin
        build(8'h98 | 8'($urandom_range(0, 7)), w);
        repeat ($urandom_range(2, 5)) fb.pop_back();
      end
      foreach (fb[i]) begin
        pgm_hold = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
        send_byte(i == 0, fb[i]);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    send_byte(1'b1, 8'h00);
    pgm_hold = 1'b0;
    idle(10);
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    checks++; if (overflow !== 1'b0) $display("FAIL rand_ovf got %b exp 0", overflow); else passed++;
    obs_q.delete(); obs_cyc.delete();
  endtask

`ifdef CHEAT_PGM_CSUM_EN
  task automatic test_csum;
    send_frame(8'h9F, 32'h01020304);
    idle(4);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {3'd7, 32'h01020304})
      $display("FAIL csum_good got n=%0d exp 1 write idx 7", obs_q.size()); else passed++;
    obs_q.delete(); obs_cyc.delete();
    build(8'h9F, 32'h01020304);
    fb[5] = 8'h00;
    foreach (fb[i]) send_byte(i == 0, fb[i]);
    idle(4);
    checks++; if (obs_q.size() != 0) $display("FAIL csum_bad_write got %0d exp 0", obs_q.size()); else passed++;
    checks++; if (csum_err !== 1'b1) $display("FAIL csum_err_set got %b exp 1", csum_err); else passed++;
    clr_status = 1'b1; idle(1); clr_status = 1'b0;
    checks++; if (csum_err !== 1'b0) $display("FAIL csum_err_clr got %b exp 0", csum_err); else passed++;
    obs_q.delete(); obs_cyc.delete();
  endtask
`endif

  task automatic test_reset_mid;
    pgm_hold = 1'b1;
    send_frame(8'h9C, $urandom);
    send_frame(8'h9D, $urandom);
    send_byte(1'b1, 8'h9E); send_byte(1'b0, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || busy !== 1'b0 || pgm_we !== 1'b0)
      $display("FAIL rstmid_out got level=%0d busy=%b we=%b exp 0", level, busy, pgm_we); else passed++;
    checks++; if (pgm_in !== 32'd0 || pgm_idx !== 3'd0 || overflow !== 1'b0)
      $display("FAIL rstmid_data got in=%h idx=%0d ovf=%b exp 0", pgm_in, pgm_idx, overflow); else passed++;
    idle(2);
    obs_q.delete(); obs_cyc.delete();
    rst_n = 1'b1;
    pgm_hold = 1'b0;
    idle(8);
    checks++; if (obs_q.size() != 0) $display("FAIL rstmid_writes got %0d exp 0", obs_q.size()); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL rstmid_level got %0d exp 0", level); else passed++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_single();
    test_overflow();
    test_abort();
    test_skip();
    test_push_pop_full();
    test_random();
`ifdef CHEAT_PGM_CSUM_EN
    test_csum();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/cheat_pgm_loader.md
Name: cheat_pgm_loader

Overview:
- Writer side of the cheat/hook programming port: turns the MCU command byte stream into `pgm_idx` / `pgm_we` / `pgm_in` word writes for the cheat engine.
- Assembles fixed-format frames and buffers completed words in a small FIFO.
- Holds writes back while the engine is inside its in-game hook (`pgm_hold`), so cheat/vector tables never change mid-handler.
- Sits between the MCU command decoder and the cheat module, on the single system clock.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- HDR_MATCH, 5'b10011, required value of header byte bits [7:3]; a valid header is therefore 0x98..0x9F.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  frame marker from MCU decoder.
- cmd_valid  in  1  one-cycle byte strobe.
- cmd_data  in  8  command byte.
- pgm_hold  in  1  engine busy (hook active); defers issuing writes.
- clr_status  in  1  clears sticky flags.
- pgm_we  out  1  one-cycle write strobe to the cheat engine.
- pgm_idx  out  3  target slot.
- pgm_in  out  32  write payload.
- busy  out  1  frame in progress OR FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: completed frame dropped because the FIFO was full.
- csum_err  out  1  sticky: checksum mismatch (0 when the feature is compiled out).

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty. All outputs 0: `pgm_we`, `pgm_idx`, `pgm_in`, `busy`, `level`, `overflow`, `csum_err`.
- Frame format: header byte, then B3..B0 with B3 first.
  - Header [7:3] must equal HDR_MATCH; header [2:0] is the slot index.
  - Word = {B3,B2,B1,B0}.
- FSM states: IDLE, PAYLOAD, CSUM (feature only), SKIP.
  - Byte counter `bcnt` is 2 bits.
- `cmd_start` is decoded with priority over the current state:
  - `cmd_start` with `cmd_valid`: this byte is a header. Any partial frame is discarded.
    - Header matches: latch index, `bcnt`=0, go to PAYLOAD.
    - Header does not match: go to SKIP.
  - `cmd_start` without `cmd_valid`: discard any partial frame, go to IDLE.
- IDLE: `cmd_valid` without `cmd_start` is treated as a header; same decode as above.
- PAYLOAD: each `cmd_valid` shifts the byte into the word and increments `bcnt`. The byte taken when `bcnt`=3 completes the frame.
  - Without the feature: push the frame, go to IDLE.
  - With the feature: go to CSUM.
- SKIP: ignore all bytes until the next `cmd_start`.
- Push/pop rules:
  - Push succeeds if FIFO not full, or if a pop happens in the same cycle.
  - Otherwise the frame is dropped and `overflow` is set.
  - Pop condition, evaluated each edge: FIFO non-empty AND `pgm_hold`=0. On pop, register the head entry onto `pgm_idx`/`pgm_in` and set `pgm_we`=1 for exactly one cycle.
  - Otherwise `pgm_we`=0. `pgm_idx`/`pgm_in` keep their last value.
- Latency: final byte sampled at edge N → entry written at N → `pgm_we` high in the cycle after edge N+1 (2 cycles), provided `pgm_hold`=0.
- Throughput: at most one write per cycle. Entries issue in FIFO order, never reordered or merged; duplicate slots are each written.
- `pgm_hold` rising while entries are queued stalls issue; the head is preserved. `pgm_hold` never truncates an issued `pgm_we` pulse.
- `level` counts 0..DEPTH. Pointers wrap modulo DEPTH.
- Sticky flags: `clr_status` clears them. If a set event and `clr_status` occur in the same cycle, the flag ends up set.
- `busy` = (state ∈ {PAYLOAD, CSUM}) OR (`level` ≠ 0).

Optional Feature:
- Macro: CHEAT_PGM_CSUM_EN.
- Defined:
  - Each frame carries a sixth byte: XOR of header and B3..B0.
  - CSUM state compares it. Match → push. Mismatch → drop frame, set `csum_err`. Either way, go to IDLE.
  - `cmd_start` during CSUM aborts the frame without setting `csum_err`.
- Undefined: 5-byte frames, no CSUM state, `csum_err` tied to 0.

Test Plan:
- Frame 0x9A,7E,00,10,FF with `pgm_hold`=0 → one `pgm_we` pulse, 2 cycles after the last byte; `pgm_idx`=2, `pgm_in`=0x7E0010FF; then `busy`=0.
- `pgm_hold`=1, send 4 frames for idx 0..3 (DEPTH=4) → `level`=4, no `pgm_we`. A 5th frame → dropped, `overflow`=1. Release hold → 4 consecutive pulses, idx 0,1,2,3 in order.
- Frame 0x9E,12,34 then `cmd_start`+0x99,AA,BB,CC,DD → only one write: idx 1, 0xAABBCCDD.
- Header 0x55 then 4 bytes, no `cmd_start` → SKIP, no write. Next `cmd_start`+0x98,... frame → writes idx 0.
- FIFO full with hold released: push and pop in the same cycle → no overflow, `level` stays 4.
- CHEAT_PGM_CSUM_EN: 0x9F,01,02,03,04,csum=0x9B → write idx 7. Same frame with csum 0x00 → no write, `csum_err`=1. Then `clr_status` → `csum_err`=0.
- Reset asserted mid-frame with queued entries → outputs 0 immediately, FIFO empty, no `pgm_we` after release.
